// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the instruction-fetch slice of the pipeline.
//   fetch_state_t    : fetch controller FSM states
//   PC_INCR          : sequential fetch stride in bytes
//   RESET_PC_DEFAULT : default first fetch address after reset
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    localparam int unsigned PC_INCR          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : riscv_pipe_pkg

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: holds the next address to fetch.
// The FSM in fetch_ctrl decides when to redirect or advance. pc_next is the
// value the register takes at the coming edge. The controller also loads
// that value into imem_addr when it issues a new request.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   redirect_en   : load redirect_pc (word-aligned) as the new fetch PC
//   redirect_pc   : redirect target
//   advance_en    : step the fetch PC by PC_INCR (wraps modulo 2^W)
//   pc_next       : fetch PC value after the coming edge
module fetch_pc_gen
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned                WORD_BITWIDTH = 32,
    parameter logic [WORD_BITWIDTH-1:0]   RESET_PC      = WORD_BITWIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     redirect_en,
    input  logic [WORD_BITWIDTH-1:0] redirect_pc,
    input  logic                     advance_en,
    output logic [WORD_BITWIDTH-1:0] pc_next
);

    // Instructions are word aligned; the two low target bits never reach the PC.
    localparam logic [WORD_BITWIDTH-1:0] ALIGN_MASK = ~WORD_BITWIDTH'(2'b11);
    localparam logic [WORD_BITWIDTH-1:0] INCR       = WORD_BITWIDTH'(PC_INCR);

    logic [WORD_BITWIDTH-1:0] pc_r;

    // Next fetch PC: redirect wins over sequential advance, otherwise hold.
    always_comb begin
        pc_next = pc_r;
        if (redirect_en) begin
            pc_next = redirect_pc & ALIGN_MASK;
        end else if (advance_en) begin
            pc_next = pc_r + INCR;
        end else begin
            pc_next = pc_r;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next;
        end
    end

endmodule : fetch_pc_gen

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller.
// Issues one instruction-memory request at a time. It presents each returned
// instruction to decode until decode accepts it (stall low). Branch redirects
// are honoured without abandoning a request already in flight. In that case
// the FSM drains the old request and then fetches the latched target.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   redirect, redirect_pc   : taken branch/jump and its target
//   stall                   : decode cannot accept the presented instruction
//   imem_req, imem_addr     : request to instruction memory (registered)
//   imem_ack, imem_rdata    : memory completion, data valid in the ack cycle
//   if_valid, if_pc, if_instr : instruction presented to decode (registered)
//   fetch_misalign          : only when FETCH_CTRL_ALIGN_CHECK_EN is defined;
//                             sticky flag for a misaligned redirect target,
//                             fetch parks until reset
module fetch_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned                WORD_BITWIDTH = 32,
    parameter logic [WORD_BITWIDTH-1:0]   RESET_PC      = WORD_BITWIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     redirect,
    input  logic [WORD_BITWIDTH-1:0] redirect_pc,
    input  logic                     stall,
    output logic                     imem_req,
    output logic [WORD_BITWIDTH-1:0] imem_addr,
    input  logic                     imem_ack,
    input  logic [WORD_BITWIDTH-1:0] imem_rdata,
    output logic                     if_valid,
    output logic [WORD_BITWIDTH-1:0] if_pc,
    output logic [WORD_BITWIDTH-1:0] if_instr
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
    ,
    output logic                     fetch_misalign
`endif
);

    fetch_state_t             state_r;
    logic [WORD_BITWIDTH-1:0] pc_next_s;
    logic                     advance_s;
    logic                     park_s;

    // Step past an instruction only when it is actually delivered to decode.
    assign advance_s = (state_r == ST_FETCH) && imem_ack && !redirect;

    fetch_pc_gen #(
        .WORD_BITWIDTH (WORD_BITWIDTH),
        .RESET_PC      (RESET_PC)
    ) u_pc_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect_en (redirect),
        .redirect_pc (redirect_pc),
        .advance_en  (advance_s),
        .pc_next     (pc_next_s)
    );

`ifdef FETCH_CTRL_ALIGN_CHECK_EN
    // Park as soon as a misaligned target is seen, and stay parked once flagged.
    assign park_s = fetch_misalign || (redirect && (redirect_pc[1:0] != 2'b00));

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_misalign <= 1'b0;
        end else if (park_s) begin
            fetch_misalign <= 1'b1;
        end else begin
            fetch_misalign <= fetch_misalign;
        end
    end
`else
    assign park_s = 1'b0;
`endif

    // Fetch FSM with registered memory-request and decode-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_BOOT;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            if_valid  <= 1'b0;
            if_pc     <= '0;
            if_instr  <= '0;
        end else if (park_s) begin
            state_r  <= ST_HOLD;
            imem_req <= 1'b0;
            if_valid <= 1'b0;
        end else begin
            case (state_r)
                // A late ack from a request cut off by reset is ignored here.
                ST_BOOT: begin
                    state_r   <= ST_FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= pc_next_s;
                end
                ST_FETCH: begin
                    if (redirect && imem_ack) begin
                        // Returned word belongs to the wrong path: drop it.
                        state_r   <= ST_FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_next_s;
                    end else if (redirect) begin
                        // Keep the request on the bus; the target is latched.
                        state_r <= ST_DRAIN;
                    end else if (imem_ack) begin
                        state_r  <= ST_HOLD;
                        imem_req <= 1'b0;
                        if_valid <= 1'b1;
                        if_pc    <= imem_addr;
                        if_instr <= imem_rdata;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (redirect || !stall) begin
                        state_r   <= ST_FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_next_s;
                        if_valid  <= 1'b0;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ack) begin
                        state_r   <= ST_FETCH;
                        imem_addr <= pc_next_s;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r  <= ST_BOOT;
                    imem_req <= 1'b0;
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl.
// Each table row describes one clock cycle. It lists the outputs expected
// before the next rising edge and the inputs driven for that cycle.
// Delivered instructions are also checked through a scoreboard queue. An
// entry is pushed when the bench acks a request that must reach decode, and
// it is popped when if_valid rises.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        stall;
        logic        ack;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    sb_t  sb_q[$];
    vec_t tbl1[$];
    vec_t tbl2[$];
    logic draining   = 1'b0;
    logic prev_valid = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input logic rd, input logic [31:0] rp, input logic st,
                                input logic ak, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep);
        vec_t v;
        v.redir = rd; v.rpc = rp; v.stall = st; v.ack = ak;
        v.ereq = er; v.eaddr = ea; v.evalid = ev; v.epc = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " imem_req"},  {31'd0, imem_req}, 32'd0);
        chk({tag, " imem_addr"}, imem_addr,         32'd0);
        chk({tag, " if_valid"},  {31'd0, if_valid}, 32'd0);
        chk({tag, " if_pc"},     if_pc,             32'd0);
        chk({tag, " if_instr"},  if_instr,          32'd0);
    endtask

    // Called on a falling edge: check outputs, drive the row, wait one cycle.
    task automatic apply_row(input vec_t v, input string tag);
        sb_t e;
        chk({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, v.ereq});
        if (v.ereq) chk({tag, " imem_addr"}, imem_addr, v.eaddr);
        chk({tag, " if_valid"}, {31'd0, if_valid}, {31'd0, v.evalid});
        if (v.evalid) begin
            chk({tag, " if_pc"},    if_pc,    v.epc);
            chk({tag, " if_instr"}, if_instr, mem_word(v.epc));
        end
        if (if_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s sb_deliver: got instruction at %h, expected none", tag, if_pc);
            end else begin
                e = sb_q.pop_front();
                chk({tag, " sb_pc"},    if_pc,    e.pc);
                chk({tag, " sb_instr"}, if_instr, e.instr);
            end
        end
        prev_valid = if_valid;

        redirect    = v.redir;
        redirect_pc = v.rpc;
        stall       = v.stall;
        imem_ack    = v.ack;
        imem_rdata  = v.ack ? mem_word(v.eaddr) : 32'hDEAD_BEEF;
        if (v.ack && v.ereq && !v.redir && !draining) begin
            e.pc    = v.eaddr;
            e.instr = mem_word(v.eaddr);
            sb_q.push_back(e);
        end
        if (v.ack && v.ereq) draining = 1'b0;
        else if (v.redir && v.ereq) draining = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        //                redir rpc           stall ack  ereq eaddr         evalid epc
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0));        // 0 BOOT
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0));        // 1
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0));        // 2
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0));        // 3
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h4,        1'b0, 32'h0));        // 4
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h4,        1'b0, 32'h0));        // 5
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h4));        // 6
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h8,        1'b0, 32'h0));        // 7
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8,        1'b0, 32'h0));        // 8
        tbl1.push_back(mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h8));        // 9 stall
        tbl1.push_back(mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h8));        // 10
        tbl1.push_back(mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h8));        // 11
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h8));        // 12 consume
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hC,        1'b0, 32'h0));        // 13
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hC));        // 14
        tbl1.push_back(mk(1'b1, 32'h100,      1'b0, 1'b0, 1'b1, 32'h10,       1'b0, 32'h0));        // 15 redirect, no ack
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h10,       1'b0, 32'h0));        // 16 drain
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h10,       1'b0, 32'h0));        // 17 drain ack
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h100,      1'b0, 32'h0));        // 18
        tbl1.push_back(mk(1'b1, 32'h14,       1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h100));      // 19 redirect in HOLD + stall
        tbl1.push_back(mk(1'b1, 32'h40,       1'b0, 1'b1, 1'b1, 32'h14,       1'b0, 32'h0));        // 20 redirect + ack
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h40,       1'b0, 32'h0));        // 21
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h40));       // 22
        tbl1.push_back(mk(1'b1, 32'h200,      1'b0, 1'b0, 1'b1, 32'h44,       1'b0, 32'h0));        // 23
        tbl1.push_back(mk(1'b1, 32'h300,      1'b0, 1'b0, 1'b1, 32'h44,       1'b0, 32'h0));        // 24 retarget in drain
        tbl1.push_back(mk(1'b1, 32'h400,      1'b0, 1'b1, 1'b1, 32'h44,       1'b0, 32'h0));        // 25 retarget on ack
        tbl1.push_back(mk(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 32'h400,     1'b0, 32'h0));        // 26
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h400,      1'b0, 32'h0));        // 27
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0));       // 28 top of memory
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC)); // 29
        tbl1.push_back(mk(1'b1, 32'h103,      1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0));        // 30 wrapped; low bits dropped
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0));        // 31
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h100,      1'b0, 32'h0));        // 32
        tbl1.push_back(mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h100));      // 33

        // After a mid-request reset: late ack in BOOT ignored, BOOT redirect.
        tbl2.push_back(mk(1'b1, 32'h80,       1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0));
        tbl2.push_back(mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h80,       1'b0, 32'h0));
        tbl2.push_back(mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h80,       1'b0, 32'h0));
        tbl2.push_back(mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h80));
        tbl2.push_back(mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h84,       1'b0, 32'h0));

        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stall       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        for (int i = 0; i < tbl1.size(); i++) begin
            apply_row(tbl1[i], $sformatf("t1_row%0d", i));
        end

        // Now in FETCH at 0x104: reset with a request outstanding.
        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        #1;
        chk_reset("async_reset");
        chk("sb_drained", sb_q.size(), 32'd0);
        sb_q.delete();
        draining   = 1'b0;
        prev_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < tbl2.size(); i++) begin
            apply_row(tbl2[i], $sformatf("t2_row%0d", i));
        end

`ifdef FETCH_CTRL_ALIGN_CHECK_EN
        chk("misalign_clear", {31'd0, fetch_misalign}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        imem_ack    = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("misalign_flag%0d", i),  {31'd0, fetch_misalign}, 32'd1);
            chk($sformatf("misalign_req%0d", i),   {31'd0, imem_req},       32'd0);
            chk($sformatf("misalign_valid%0d", i), {31'd0, if_valid},       32'd0);
            redirect    = (i == 1);
            redirect_pc = 32'h200;
            stall       = 1'b0;
            imem_ack    = (i == 2);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("misalign_reset", {31'd0, fetch_misalign}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        chk("sb_final_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_ctrl

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter WORD_BITWIDTH, default 32, width of PC, addresses and instruction words.
REQ-002 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 redirect  input  1  branch/jump taken; overrides sequential fetch.
REQ-006 redirect_pc  input  WORD_BITWIDTH  target address, valid with redirect.
REQ-007 stall  input  1  decode cannot accept; hold presented instruction.
REQ-008 imem_req  output  1  fetch request to instruction memory.
REQ-009 imem_addr  output  WORD_BITWIDTH  fetch address, valid with imem_req.
REQ-010 imem_ack  input  1  memory completes request; imem_rdata valid same cycle.
REQ-011 imem_rdata  input  WORD_BITWIDTH  fetched instruction.
REQ-012 if_valid  output  1  if_pc/if_instr hold a live instruction for decode.
REQ-013 if_pc  output  WORD_BITWIDTH  address of presented instruction.
REQ-014 if_instr  output  WORD_BITWIDTH  presented instruction.

Function
REQ-015 FSM states: BOOT, FETCH, HOLD, DRAIN; BOOT after reset, then FETCH unconditionally next cycle.
REQ-016 FETCH: imem_req=1, imem_addr=fetch_pc; both held stable until imem_ack; one request outstanding max.
REQ-017 FETCH + imem_ack + no redirect: next cycle if_valid=1, if_pc=imem_addr, if_instr=imem_rdata, fetch_pc=imem_addr+4 (modulo 2^WORD_BITWIDTH, wraps silently), state HOLD.
REQ-018 HOLD: imem_req=0; stall=1 keeps if_valid/if_pc/if_instr unchanged; stall=0 means consumed -> next cycle if_valid=0, state FETCH (max throughput one instruction per 2 cycles).
REQ-019 Redirect priority over stall and ack; last redirect_pc sampled before the next request wins.
REQ-020 Redirect in HOLD: next cycle if_valid=0, fetch_pc=redirect_pc, state FETCH, regardless of stall.
REQ-021 Redirect in FETCH without imem_ack: request not abandoned; fetch_pc target latched, state DRAIN.
REQ-022 Redirect in FETCH with imem_ack same cycle: rdata discarded, if_valid stays 0, fetch_pc=redirect_pc, state FETCH.
REQ-023 DRAIN: imem_req=1 with original address until imem_ack; ack data discarded, then FETCH at latched target; further redirects update target.
REQ-024 Redirect in BOOT: fetch_pc=redirect_pc, proceed to FETCH.

Reset
REQ-025 rst_n low: state BOOT, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, asynchronously.
REQ-026 Reset mid-request: outstanding request dropped; late imem_ack ignored in BOOT.

Configuration
REQ-027 Macro FETCH_CTRL_ALIGN_CHECK_EN defined: output fetch_misalign (1 bit) added; redirect_pc[1:0]!=0 sets fetch_misalign sticky, FSM parks in HOLD with if_valid=0, imem_req=0 until reset.
REQ-028 Macro undefined: no fetch_misalign port; redirect_pc[1:0] ignored (forced to 0 in fetch_pc).

Structure
REQ-029 Package riscv_pipe_pkg holds fetch state enum, PC_INCR=4, RESET_PC default.
REQ-030 Sub-module fetch_pc_gen: fetch_pc register, +4 adder, redirect mux; FSM stays in fetch_ctrl.

Verification
REQ-031 Reset release, ack 1 cycle after each req, stall=0 -> imem_addr 0,4,8; if_pc 0,4,8 each with one-cycle if_valid.
REQ-032 HOLD with if_pc=0x8, stall=1 for 3 cycles -> if_valid/if_instr stable, imem_req=0; stall=0 -> next req addr 0xC.
REQ-033 Redirect to 0x100 while req at 0x10 unacked, ack 2 cycles later -> addr 0x10 held, no if_valid, next req 0x100.
REQ-034 Redirect to 0x40 same cycle as ack at 0x14 -> if_valid never 1 for 0x14; next req 0x40.
REQ-035 fetch_pc=0xFFFFFFFC acked -> next req 0x00000000.
REQ-036 With FETCH_CTRL_ALIGN_CHECK_EN, redirect to 0x102 -> fetch_misalign=1, imem_req=0 until rst_n low.
